ram_arbiter: RTL and testbench

Access controller for the single-write-port / single-read-port frame RAM. It shares the one write port between two pixel writers using round-robin arbitration. It serves one reader with a fixed-latency read pipeline and blocks read-during-write hazards. It also sequences a full-memory clear. The block sits between the pattern generators / display reader and the RAM, and drives the RAM's WRITE_EN, READ_EN, address and data pins directly from registers.

---
 rtl/ram_arbiter.sv | 133 +++++++++++++
 tb/tb_ram_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: front end for a one-write-port / one-read-port frame RAM.
// Two pixel writers share the write port with round-robin priority. One reader
// gets a fixed two-edge read pipeline, with read-during-write hazards stalled.
// A full-memory clear sequence is also provided. All RAM pins come straight
// from flops.
module ram_arbiter #(
    parameter int                    ADDRESS_WIDTH = 20,
    parameter int                    DATA_WIDTH    = 15,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE   = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr0_valid,
    input  logic [ADDRESS_WIDTH-1:0] wr0_addr,
    input  logic [DATA_WIDTH-1:0]    wr0_data,
    output logic                     wr0_ready,
    input  logic                     wr1_valid,
    input  logic [ADDRESS_WIDTH-1:0] wr1_addr,
    input  logic [DATA_WIDTH-1:0]    wr1_data,
    output logic                     wr1_ready,
    input  logic                     rd_valid,
    input  logic [ADDRESS_WIDTH-1:0] rd_addr,
    output logic                     rd_ready,
    output logic                     rd_data_valid,
    output logic [DATA_WIDTH-1:0]    rd_data,
    input  logic                     clear_start,
    output logic                     busy,
    output logic                     clear_done,
    output logic                     WRITE_EN,
    output logic                     READ_EN,
    output logic [ADDRESS_WIDTH-1:0] ram_wr_addr,
    output logic [ADDRESS_WIDTH-1:0] ram_rd_addr,
    output logic [DATA_WIDTH-1:0]    ram_din,
    input  logic [DATA_WIDTH-1:0]    ram_dout
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};

    state_t                   state;
    logic                     prio;     // writer index that wins a tie next
    logic [ADDRESS_WIDTH-1:0] counter;  // clear address
    logic                     grant0;
    logic                     grant1;
    logic                     hazard;

    // Round-robin write grant and same-address read hazard, only while idle.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through it leaves a value held and no latch is inferred.
        grant0 = 1'b0;
        grant1 = 1'b0;
        hazard = 1'b0;
        if (state == IDLE) begin
            grant0 = wr0_valid && (!wr1_valid || !prio);
            grant1 = wr1_valid && (!wr0_valid ||  prio);
            // A read issued alongside a write to the same word would see the
            // old contents, so the read waits one cycle.
            hazard = (grant0 && (wr0_addr == rd_addr)) ||
                     (grant1 && (wr1_addr == rd_addr));
        end
    end

    assign wr0_ready = grant0;
    assign wr1_ready = grant1;
    assign rd_ready  = (state == IDLE) && !hazard;
    assign busy      = (state == CLEAR);
    assign rd_data   = ram_dout;

    // Controller state, arbitration pointer and all registered RAM pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            counter       <= '0;
            prio          <= 1'b0;
            WRITE_EN      <= 1'b0;
            READ_EN       <= 1'b0;
            rd_data_valid <= 1'b0;
            clear_done    <= 1'b0;
            ram_wr_addr   <= '0;
            ram_rd_addr   <= '0;
            ram_din       <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every flop here
            // samples the values from before this edge regardless of order.
            rd_data_valid <= READ_EN;
            WRITE_EN      <= 1'b0;
            READ_EN       <= 1'b0;
            clear_done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant0) begin
                        WRITE_EN    <= 1'b1;
                        ram_wr_addr <= wr0_addr;
                        ram_din     <= wr0_data;
                        prio        <= 1'b1;
                    end else if (grant1) begin
                        WRITE_EN    <= 1'b1;
                        ram_wr_addr <= wr1_addr;
                        ram_din     <= wr1_data;
                        prio        <= 1'b0;
                    end
                    if (rd_valid && rd_ready) begin
                        READ_EN     <= 1'b1;
                        ram_rd_addr <= rd_addr;
                    end
                    if (clear_start) begin
                        state   <= CLEAR;
                        counter <= '0;
                    end
                end
                CLEAR: begin
                    WRITE_EN    <= 1'b1;
                    ram_wr_addr <= counter;
                    ram_din     <= CLEAR_VALUE;
                    if (counter == '1) begin
                        state      <= IDLE;
                        clear_done <= 1'b1;
                        counter    <= '0;
                    end else begin
                        counter <= counter + ADDR_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: table vectors, hand sequences and random traffic for
// ram_arbiter. A behavioural RAM sits on the RAM pins. A reference model tracks
// memory contents, the round-robin pointer, the clear progress and the expected
// read returns.
module tb_ram_arbiter;

    localparam int            AW    = 4;
    localparam int            DW    = 15;
    localparam int            DEPTH = 16;
    localparam logic [DW-1:0] CV    = 15'h7FFF;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr0_valid, wr1_valid, rd_valid, clear_start;
    logic [AW-1:0] wr0_addr, wr1_addr, rd_addr;
    logic [DW-1:0] wr0_data, wr1_data;
    logic          wr0_ready, wr1_ready, rd_ready, rd_data_valid;
    logic [DW-1:0] rd_data;
    logic          busy, clear_done, WRITE_EN, READ_EN;
    logic [AW-1:0] ram_wr_addr, ram_rd_addr;
    logic [DW-1:0] ram_din, ram_dout;

    ram_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .CLEAR_VALUE(CV)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr0_valid(wr0_valid), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_ready(wr0_ready),
        .wr1_valid(wr1_valid), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_ready(wr1_ready),
        .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready),
        .rd_data_valid(rd_data_valid), .rd_data(rd_data),
        .clear_start(clear_start), .busy(busy), .clear_done(clear_done),
        .WRITE_EN(WRITE_EN), .READ_EN(READ_EN),
        .ram_wr_addr(ram_wr_addr), .ram_rd_addr(ram_rd_addr),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // Frame RAM: registered read, read-before-write on a same-address collision.
    logic [DW-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (WRITE_EN) ram[ram_wr_addr] <= ram_din;
        if (READ_EN)  ram_dout <= ram[ram_rd_addr];
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } rd_exp_t;

    logic [DW-1:0] m_mem [DEPTH];
    rd_exp_t       rq[$];
    logic          m_prio = 1'b0;
    logic          m_busy = 1'b0;
    logic          m_we = 1'b0, m_re = 1'b0, m_done = 1'b0;
    logic [AW-1:0] m_we_addr, m_re_addr;
    logic [DW-1:0] m_we_data;
    int            m_clr = 0;
    bit            m_last_wr = 1'b0;
    int            m_last_addr = 0;
    logic [DW-1:0] m_last_old;
    int            cyc = 0;

    task automatic model_ready(output logic e0, output logic e1, output logic er);
        e0 = 1'b0; e1 = 1'b0; er = 1'b0;
        if (!m_busy) begin
            if (wr0_valid && wr1_valid) begin
                e0 = (m_prio == 1'b0);
                e1 = (m_prio == 1'b1);
            end else begin
                e0 = wr0_valid;
                e1 = wr1_valid;
            end
            er = !((e0 && wr0_addr == rd_addr) || (e1 && wr1_addr == rd_addr));
        end
    endtask

    // A write issued at the last edge never reaches the RAM if reset hits first.
    task automatic model_reset();
        if (m_last_wr) m_mem[m_last_addr] = m_last_old;
        m_last_wr = 1'b0;
        rq.delete();
        m_prio = 1'b0; m_busy = 1'b0; m_clr = 0;
        m_we = 1'b0; m_re = 1'b0; m_done = 1'b0;
    endtask

    // One clock: check readies mid-cycle, advance the model at the edge,
    // then check registered outputs just after the edge.
    task automatic tick(input bit use_tab, input logic t0, input logic t1, input logic tr);
        logic    e0, e1, er, exp_v;
        rd_exp_t r;
        @(negedge clk);
        model_ready(e0, e1, er);
        if (use_tab) begin
            check("tab_wr0_ready", wr0_ready, t0);
            check("tab_wr1_ready", wr1_ready, t1);
            check("tab_rd_ready",  rd_ready,  tr);
        end else begin
            check("wr0_ready", wr0_ready, e0);
            check("wr1_ready", wr1_ready, e1);
            check("rd_ready",  rd_ready,  er);
        end
        @(posedge clk);
        cyc++;
        m_we = 1'b0; m_re = 1'b0; m_done = 1'b0; m_last_wr = 1'b0;
        if (m_busy) begin
            m_last_wr = 1'b1; m_last_addr = m_clr; m_last_old = m_mem[m_clr];
            m_mem[m_clr] = CV;
            m_we = 1'b1; m_we_addr = AW'(m_clr); m_we_data = CV;
            if (m_clr == DEPTH - 1) begin
                m_busy = 1'b0; m_done = 1'b1; m_clr = 0;
            end else begin
                m_clr++;
            end
        end else begin
            if (rd_valid && er) begin
                r.due = cyc + 1; r.data = m_mem[rd_addr];
                rq.push_back(r);
                m_re = 1'b1; m_re_addr = rd_addr;
            end
            if (e0) begin
                m_last_wr = 1'b1; m_last_addr = int'(wr0_addr); m_last_old = m_mem[wr0_addr];
                m_mem[wr0_addr] = wr0_data;
                m_we = 1'b1; m_we_addr = wr0_addr; m_we_data = wr0_data; m_prio = 1'b1;
            end else if (e1) begin
                m_last_wr = 1'b1; m_last_addr = int'(wr1_addr); m_last_old = m_mem[wr1_addr];
                m_mem[wr1_addr] = wr1_data;
                m_we = 1'b1; m_we_addr = wr1_addr; m_we_data = wr1_data; m_prio = 1'b0;
            end
            if (clear_start) begin
                m_busy = 1'b1; m_clr = 0;
            end
        end
        #1;
        check("WRITE_EN", WRITE_EN, m_we);
        if (m_we) begin
            check("ram_wr_addr", ram_wr_addr, m_we_addr);
            check("ram_din", ram_din, m_we_data);
        end
        check("READ_EN", READ_EN, m_re);
        if (m_re) check("ram_rd_addr", ram_rd_addr, m_re_addr);
        check("busy", busy, m_busy);
        check("clear_done", clear_done, m_done);
        exp_v = (rq.size() > 0) && (rq[0].due == cyc);
        check("rd_data_valid", rd_data_valid, exp_v);
        if (exp_v) begin
            check("rd_data", rd_data, rq[0].data);
            void'(rq.pop_front());
        end
    endtask

    task automatic tick_m();
        tick(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle_inputs();
        wr0_valid = 1'b0; wr1_valid = 1'b0; rd_valid = 1'b0; clear_start = 1'b0;
        wr0_addr = '0; wr1_addr = '0; rd_addr = '0; wr0_data = '0; wr1_data = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_WRITE_EN"}, WRITE_EN, 1'b0);
        check({tag, "_READ_EN"}, READ_EN, 1'b0);
        check({tag, "_rd_data_valid"}, rd_data_valid, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_clear_done"}, clear_done, 1'b0);
        check({tag, "_ram_wr_addr"}, ram_wr_addr, '0);
        check({tag, "_ram_rd_addr"}, ram_rd_addr, '0);
        check({tag, "_ram_din"}, ram_din, '0);
    endtask

    // Back-to-back reads of every address with rd_valid held high.
    task automatic read_all(input string tag);
        int n_valid = 0;
        idle_inputs();
        for (int i = 0; i < DEPTH; i++) begin
            rd_valid = 1'b1; rd_addr = AW'(i);
            tick_m();
            if (rd_data_valid) n_valid++;
        end
        rd_valid = 1'b0;
        repeat (2) begin
            tick_m();
            if (rd_data_valid) n_valid++;
        end
        check({tag, "_valid_count"}, n_valid, DEPTH);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic          w0v, w1v;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d0, d1;
        logic          rv;
        logic [AW-1:0] ra;
        logic          e0, e1, er;
    } vec_t;

    localparam int NVEC = 12;
    vec_t tab [NVEC];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] v;
        int busy_cnt, done_cnt, wr_cnt;

        // Random initial frame contents, mirrored in the model.
        for (int i = 0; i < DEPTH; i++) begin
            v = DW'($urandom);
            ram[i] <= v;
            m_mem[i] = v;
        end

        //         w0v   w1v   a0     a1     d0        d1        rv    ra     e0    e1    er
        tab[0]  = '{1'b1, 1'b1, 4'd0,  4'd8,  15'h0100, 15'h0800, 1'b0, 4'd15, 1'b1, 1'b0, 1'b1};
        tab[1]  = '{1'b1, 1'b1, 4'd1,  4'd9,  15'h0101, 15'h0909, 1'b0, 4'd15, 1'b0, 1'b1, 1'b1};
        tab[2]  = '{1'b1, 1'b1, 4'd2,  4'd10, 15'h0202, 15'h0A0A, 1'b0, 4'd15, 1'b1, 1'b0, 1'b1};
        tab[3]  = '{1'b1, 1'b1, 4'd3,  4'd11, 15'h0303, 15'h0B0B, 1'b0, 4'd15, 1'b0, 1'b1, 1'b1};
        tab[4]  = '{1'b0, 1'b1, 4'd0,  4'd5,  15'h0000, 15'h2AAA, 1'b1, 4'd5,  1'b0, 1'b1, 1'b0};
        tab[5]  = '{1'b0, 1'b0, 4'd0,  4'd0,  15'h0000, 15'h0000, 1'b1, 4'd5,  1'b0, 1'b0, 1'b1};
        tab[6]  = '{1'b1, 1'b0, 4'd3,  4'd0,  15'h1234, 15'h0000, 1'b0, 4'd0,  1'b1, 1'b0, 1'b1};
        tab[7]  = '{1'b0, 1'b0, 4'd0,  4'd0,  15'h0000, 15'h0000, 1'b1, 4'd3,  1'b0, 1'b0, 1'b1};
        tab[8]  = '{1'b1, 1'b1, 4'd4,  4'd12, 15'h0444, 15'h0CCC, 1'b0, 4'd0,  1'b0, 1'b1, 1'b1};
        tab[9]  = '{1'b1, 1'b0, 4'd6,  4'd0,  15'h0666, 15'h0000, 1'b1, 4'd7,  1'b1, 1'b0, 1'b1};
        tab[10] = '{1'b0, 1'b1, 4'd0,  4'd7,  15'h0000, 15'h0777, 1'b1, 4'd7,  1'b0, 1'b1, 1'b0};
        tab[11] = '{1'b1, 1'b1, 4'd9,  4'd9,  15'h1999, 15'h2999, 1'b1, 4'd9,  1'b1, 1'b0, 1'b0};

        // Reset state.
        rst_n = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick_m();

        // Arbitration, hazard stall and single-writer read-back.
        for (int i = 0; i < NVEC; i++) begin
            wr0_valid = tab[i].w0v; wr0_addr = tab[i].a0; wr0_data = tab[i].d0;
            wr1_valid = tab[i].w1v; wr1_addr = tab[i].a1; wr1_data = tab[i].d1;
            rd_valid  = tab[i].rv;  rd_addr  = tab[i].ra;
            tick(1'b1, tab[i].e0, tab[i].e1, tab[i].er);
        end
        idle_inputs();
        repeat (2) tick_m();
        read_all("b2b_reads");

        // Full clear with every requester asserted throughout.
        clear_start = 1'b1;
        tick_m();
        clear_start = 1'b0;
        busy_cnt = busy ? 1 : 0;
        done_cnt = 0;
        wr_cnt   = 0;
        wr0_valid = 1'b1; wr0_addr = 4'd2;  wr0_data = 15'h0055;
        wr1_valid = 1'b1; wr1_addr = 4'd13; wr1_data = 15'h00AA;
        rd_valid  = 1'b1; rd_addr  = 4'd6;
        for (int k = 1; k <= 17; k++) begin
            if (k == 17) begin
                wr0_valid = 1'b0; wr1_valid = 1'b0; rd_valid = 1'b0;
            end
            clear_start = (k == 5);
            tick_m();
            if (busy) busy_cnt++;
            if (clear_done) done_cnt++;
            if (WRITE_EN) begin
                check("clear_addr_order", ram_wr_addr, wr_cnt);
                wr_cnt++;
            end
        end
        check("clear_busy_cycles", busy_cnt, 16);
        check("clear_done_pulses", done_cnt, 1);
        check("clear_write_count", wr_cnt, 16);
        read_all("after_clear");

        // Fresh data in the upper half, then reset once address 7 is issued.
        idle_inputs();
        for (int i = 8; i < DEPTH; i++) begin
            wr0_valid = 1'b1; wr0_addr = AW'(i); wr0_data = DW'($urandom);
            tick_m();
        end
        idle_inputs();
        tick_m();
        clear_start = 1'b1;
        tick_m();
        clear_start = 1'b0;
        repeat (8) tick_m();
        check("midclear_addr_before_reset", ram_wr_addr, 4'd7);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midclear_reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick_m();
        check("busy_after_reset_release", busy, 1'b0);
        read_all("after_abandoned_clear");

        // Random traffic against the model.
        for (int i = 0; i < 500; i++) begin
            wr0_valid   = ($urandom_range(0, 9) < 6);
            wr1_valid   = ($urandom_range(0, 9) < 6);
            rd_valid    = ($urandom_range(0, 9) < 7);
            clear_start = ($urandom_range(0, 149) == 0);
            wr0_addr = AW'($urandom); wr1_addr = AW'($urandom); rd_addr = AW'($urandom);
            wr0_data = DW'($urandom); wr1_data = DW'($urandom);
            tick_m();
        end
        idle_inputs();
        repeat (20) tick_m();
        read_all("final_reads");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
